// File: rtl/mcs4_clkgen.sv
// mcs4_clkgen: two-phase clock and power-on-clear sequencer for the 4004 core.
//
// Each period is four phase slots of CLK_DIV sysclk cycles. clk1_pad is high
// in slot 0 and clk2_pad is high in slot 2, so the two phases never overlap.
// Eight periods form one instruction cycle. poc_pad is held high until
// POC_CYCLES complete instruction cycles have run since reset or por_req
// release.
//
// Optional feature macro: MCS4_CLKGEN_STEP_EN
//   defined   - run/step drive a RUN/HALT/STEP FSM that can stop the clocks
//               on instruction-cycle boundaries.
//   undefined - clocks always free-run, run/step are ignored, halted is 0.
//
// Ports:
//   sysclk    in   system clock, all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   por_req   in   level request to re-run power-on-clear
//   run       in   1 = free-run, 0 = halt at next cycle boundary
//   step      in   one-sysclk pulse, run one instruction cycle while halted
//   clk1_pad  out  phase-1 clock to CPU
//   clk2_pad  out  phase-2 clock to CPU
//   poc_pad   out  power-on-clear to CPU
//   cyc_start out  one-sysclk pulse as period 0 slot 0 begins
//   period    out  clock-period index within the instruction cycle (0..7)
//   halted    out  clocks stopped at a cycle boundary

module mcs4_clkgen #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned POC_CYCLES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       por_req,
    input  logic       run,
    input  logic       step,
    output logic       clk1_pad,
    output logic       clk2_pad,
    output logic       poc_pad,
    output logic       cyc_start,
    output logic [2:0] period,
    output logic       halted
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned POC_W = $clog2(POC_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POC_W-1:0] POC_LAST = POC_W'(POC_CYCLES);

    // Position currently driven on the pads. active_q=0 means the clocks are
    // stopped (after reset or while halted) and the next running edge starts
    // again at period 0 slot 0.
    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d, div_nx;
    logic [1:0]       slot_q, slot_d, slot_nx;
    logic [2:0]       per_q, per_d, per_nx;

    logic             clk1_q, clk1_d;
    logic             clk2_q, clk2_d;
    logic             cyc_q, cyc_d;

    logic             poc_q, poc_d;
    logic [POC_W-1:0] poc_cnt_q, poc_cnt_d, poc_inc;
    // Set once a cycle has started with por_req low, so a cycle that was
    // already under way at por_req release is not counted as complete.
    logic             armed_q, armed_d;

    logic             cycle_end;
    logic             go;

`ifdef MCS4_CLKGEN_STEP_EN
    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_STEP
    } state_e;

    state_e state_q, state_d;
    logic   halted_q, halted_d;
`endif

    // Position advance and end-of-instruction-cycle detection.
    always_comb begin
        div_nx  = div_q + 1'b1;
        slot_nx = slot_q;
        per_nx  = per_q;
        if (div_q == DIV_LAST) begin
            div_nx  = '0;
            slot_nx = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                per_nx = per_q + 3'd1;
            end
        end
        cycle_end = active_q && (div_q == DIV_LAST) && (slot_q == 2'd3) &&
                    (per_q == 3'd7);
    end

`ifdef MCS4_CLKGEN_STEP_EN
    // go decides whether the next edge drives clocks; the FSM only changes
    // it on cycle boundaries or when leaving HALT.
    always_comb begin
        state_d = state_q;
        go      = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (cycle_end && !run && !poc_q && !por_req) begin
                    state_d = ST_HALT;
                    go      = 1'b0;
                end
            end
            ST_HALT: begin
                if (por_req || run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end else begin
                    go = 1'b0;
                end
            end
            ST_STEP: begin
                if (cycle_end) begin
                    if (run || poc_q || por_req) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HALT;
                        go      = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end
`else
    assign go = 1'b1;

    logic unused_inputs;
    assign unused_inputs = run ^ step;
`endif

    // Next pad position and registered pad values.
    always_comb begin
        active_d = 1'b0;
        div_d    = '0;
        slot_d   = '0;
        per_d    = '0;
        if (go) begin
            active_d = 1'b1;
            if (active_q) begin
                div_d  = div_nx;
                slot_d = slot_nx;
                per_d  = per_nx;
            end
        end
        clk1_d = active_d && (slot_d == 2'd0);
        clk2_d = active_d && (slot_d == 2'd2);
        cyc_d  = active_d && (slot_d == 2'd0) && (div_d == '0) &&
                 (per_d == 3'd0);
    end

    // Power-on-clear: counts complete instruction cycles and drops poc on
    // the edge that starts the cycle after the last counted one.
    always_comb begin
        poc_d     = poc_q;
        poc_cnt_d = poc_cnt_q;
        armed_d   = armed_q;
        poc_inc   = poc_cnt_q + 1'b1;
        if (por_req) begin
            poc_d     = 1'b1;
            poc_cnt_d = '0;
            armed_d   = 1'b0;
        end else begin
            if (cycle_end && armed_q && poc_q) begin
                if (poc_inc == POC_LAST) begin
                    poc_d     = 1'b0;
                    poc_cnt_d = '0;
                end else begin
                    poc_cnt_d = poc_inc;
                end
            end
            if (cyc_d) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            active_q  <= 1'b0;
            div_q     <= '0;
            slot_q    <= '0;
            per_q     <= '0;
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            cyc_q     <= 1'b0;
            poc_q     <= 1'b1;
            poc_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            active_q  <= active_d;
            div_q     <= div_d;
            slot_q    <= slot_d;
            per_q     <= per_d;
            clk1_q    <= clk1_d;
            clk2_q    <= clk2_d;
            cyc_q     <= cyc_d;
            poc_q     <= poc_d;
            poc_cnt_q <= poc_cnt_d;
            armed_q   <= armed_d;
        end
    end

`ifdef MCS4_CLKGEN_STEP_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign clk1_pad  = clk1_q;
    assign clk2_pad  = clk2_q;
    assign cyc_start = cyc_q;
    assign poc_pad   = poc_q;
    assign period    = per_q;

endmodule

// File: doc/mcs4_clkgen.md
Name: mcs4_clkgen

Overview:
- Two-phase clock and power-on-clear sequencer for the 4004 core.
- Derives non-overlapping clk1_pad/clk2_pad from sysclk, counts clock periods into 8-period instruction cycles, and holds poc_pad until a programmed number of instruction cycles has run.
- Optionally halts or single-steps the CPU on instruction-cycle boundaries.
- Sits between the board clock/reset and the CPU timing/I-O pad inputs.

Parameters:
- CLK_DIV, 4: sysclk cycles per phase slot; must be ≥1.
- POC_CYCLES, 2: instruction cycles poc_pad stays high after reset/por_req release; must be ≥1.

Ports:
- sysclk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- por_req  in  1  level request to re-run power-on-clear.
- run  in  1  1 = free-run, 0 = halt at next cycle boundary (STEP_EN only).
- step  in  1  one-sysclk pulse: execute one instruction cycle while halted (STEP_EN only).
- clk1_pad  out  1  phase-1 clock to CPU.
- clk2_pad  out  1  phase-2 clock to CPU.
- poc_pad  out  1  power-on-clear to CPU.
- cyc_start  out  1  one-sysclk pulse on clk1_pad rise of period 0.
- period  out  3  clock-period index within instruction cycle, 0..7.
- halted  out  1  clocks stopped at boundary.

Behaviour:
- All outputs registered.
- During reset: clk1_pad=0, clk2_pad=0, poc_pad=1, cyc_start=0, period=0, halted=0. Internal slot=0, div count=0, POC count=0, FSM=RUN.
- Clock period: 4 slots of CLK_DIV sysclk each.
  - slot0: clk1=1.
  - slot1: both 0.
  - slot2: clk2=1.
  - slot3: both 0.
  - clk1 and clk2 are never high in the same cycle. Period = 4*CLK_DIV sysclk; instruction cycle = 32*CLK_DIV.
- First rising edge with reset=0: clk1_pad=1, period=0, cyc_start=1.
- period increments at the end of slot3 and wraps 7→0. cyc_start fires every time period 0 slot0 begins.
- POC:
  - poc_pad stays 1 while reset or por_req is high.
  - After release, poc_pad stays 1 for exactly POC_CYCLES complete instruction cycles, counted at each period-7 slot3 end. It drops with the cyc_start of the following cycle.
  - por_req asserted mid-count restarts the count and keeps poc_pad=1; clocks are not disturbed.
- FSM (STEP_EN): RUN, HALT, STEP.
  - RUN→HALT: at the last sysclk of period 7 slot3, if run=0 and poc_pad=0. Clocks stay 0, period=0, halted=1 from the next edge.
  - HALT→RUN: on run=1. HALT→STEP: on step=1 with run=0. Either transition resumes with clk1_pad=1, cyc_start=1 on the next edge; halted=0.
  - STEP→HALT: at the end of that cycle if run=0. STEP→RUN: if run=1.
  - step while not HALT is ignored.
  - por_req or reset in HALT forces RUN; POC always runs clocks.
  - Simultaneous run=1 and step=1 in HALT: RUN.
- Reset mid-period: clocks drop to 0 on the next edge; no partial-pulse guarantee is required.

Optional Feature:
- Macro MCS4_CLKGEN_STEP_EN.
- Defined: run/step inputs and the RUN/HALT/STEP FSM are active.
- Undefined: run/step are ignored, clocks are free-running always, halted is tied 0, and no FSM logic is built.

Test Plan:
- CLK_DIV=2, POC_CYCLES=2, release reset → clk1_pad high on sysclk 0-1, clk2_pad high on 4-5, period=1 at sysclk 8, cyc_start every 64 sysclk, clk1&clk2 never both 1.
- Same config → poc_pad=1 for first 128 sysclk after release, 0 from sysclk 128 onward.
- por_req pulsed 3 sysclk at sysclk 100 (poc already dropping) → poc_pad=1 from 101, falls 2 full cycles after por_req release on a cyc_start edge; clock pattern unbroken.
- STEP_EN, run=0 at sysclk 200 (after POC) → clocks stop after period 7 completes at sysclk 256, halted=1, period=0.
- STEP_EN, halted, step pulse → exactly 8 clk1 and 8 clk2 pulses (64 sysclk), then halted=1 again; step pulse while running → no effect.
- STEP_EN undefined, run=0 and step toggled → clocks free-run, halted=0 throughout.
